// File: rtl/serial_pat_pkg.sv
// Shared definitions for the serial 110-pattern test path.
// Holds the transmitter FSM encoding and the pattern constant that the
// detector also uses.
package serial_pat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Pattern searched for in the serial stream, oldest bit in the MSB.
   localparam logic [2:0] PAT_110 = 3'b110;

endpackage

// File: rtl/serial_pattern_gen.sv
// Serial frame transmitter: loads a word on start, sends it MSB-first.
// Latency: first bit one cycle after the accepting edge, done one cycle after the last bit.
// Backpressure: start is honoured only while ready is high and ignored otherwise.
module serial_pattern_gen
   import serial_pat_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             done,
   output logic [CNT_W-1:0] exp_count
);

   localparam int               IDX_W    = $clog2(WIDTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [IDX_W-1:0] idx;
   logic [1:0]       hist;
   logic [CNT_W-1:0] cnt;
   logic             cur_bit;

   // The bit being presented is always the top of the shift register.
   assign cur_bit   = shreg[WIDTH-1];
   assign exp_count = cnt;

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      bit_valid = 1'b0;
      bit_out   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            bit_valid = 1'b1;
            bit_out   = cur_bit;
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Frame capture, shifting, bit history and saturating pattern count.
   // History is cleared on every accepted start so patterns never span frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         idx   <= '0;
         hist  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= data;
                  idx   <= '0;
                  hist  <= '0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               idx   <= idx + IDX_W'(1);
               hist  <= {hist[0], cur_bit};
               if (({hist, cur_bit} == PAT_110) && (cnt != CNT_MAX)) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed and random frames against a
// reference model that counts 110 windows directly in the frame word.
// Two instances (4-bit and 3-bit count) share all stimulus.
module tb_serial_pattern_gen;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] data;

   logic         ready, bit_out, bit_valid, done;
   logic [3:0]   exp_count;
   logic         ready3, bit_out3, bit_valid3, done3;
   logic [2:0]   exp_count3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_pattern_gen #(.WIDTH(W), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data      (data),
      .ready     (ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .done      (done),
      .exp_count (exp_count)
   );

   serial_pattern_gen #(.WIDTH(W), .CNT_W(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data      (data),
      .ready     (ready3),
      .bit_out   (bit_out3),
      .bit_valid (bit_valid3),
      .done      (done3),
      .exp_count (exp_count3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Number of 110 windows fully contained in the first n frame bits
   // (bit 0 = MSB), clipped to cap.
   function automatic int model_count(input logic [W-1:0] d, input int n, input int cap);
      int c = 0;
      for (int j = 2; j < n; j++) begin
         if (d[W+1-j] && d[W-j] && !d[W-1-j]) c++;
      end
      return (c > cap) ? cap : c;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_valid"}, bit_valid, 0);
      chk({tag, "_bit"}, bit_out, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ready3"}, ready3, 1);
      chk({tag, "_valid3"}, bit_valid3, 0);
   endtask

   // Called at a negedge in an IDLE cycle. hold keeps start high for the
   // whole frame, noise pulses start with fresh data mid-frame, abort_at
   // asserts reset while that bit index is presented (-1 = never).
   task automatic send_frame(input logic [W-1:0] d, input bit hold, input bit noise,
                             input int abort_at);
      chk("accept_ready", ready, 1);
      start = 1'b1;
      data  = d;
      @(posedge clk);
      @(negedge clk);
      data  = $urandom;
      start = hold;
      for (int k = 0; k < W; k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
            #1;
            chk("abort_valid", bit_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_cnt", exp_count, 0);
            chk("abort_cnt3", exp_count3, 0);
            chk("abort_ready", ready, 1);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk_idle("post_abort");
            end
            return;
         end
         chk("sh_valid", bit_valid, 1);
         chk("sh_bit", bit_out, d[W-1-k]);
         chk("sh_ready", ready, 0);
         chk("sh_done", done, 0);
         chk("sh_cnt", exp_count, model_count(d, k, 15));
         chk("sh_bit3", bit_out3, d[W-1-k]);
         chk("sh_cnt3", exp_count3, model_count(d, k, 7));
         if (noise) begin
            start = hold || (k == 4) || (k == 19);
            data  = $urandom;
         end
         @(negedge clk);
      end
      chk("dn_done", done, 1);
      chk("dn_valid", bit_valid, 0);
      chk("dn_bit", bit_out, 0);
      chk("dn_ready", ready, 0);
      chk("dn_cnt", exp_count, model_count(d, W, 15));
      chk("dn_cnt3", exp_count3, model_count(d, W, 7));
      chk("dn_done3", done3, 1);
      @(negedge clk);
      chk("end_ready", ready, 1);
      chk("end_done", done, 0);
      chk("end_valid", bit_valid, 0);
      chk("end_cnt", exp_count, model_count(d, W, 15));
      chk("end_cnt3", exp_count3, model_count(d, W, 7));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      chk_idle("rst");
      chk("rst_cnt", exp_count, 0);
      chk("rst_cnt3", exp_count3, 0);
      reset = 1'b0;
      @(negedge clk);
      chk_idle("rst_rel");

      send_frame(32'hC000_0000, 1'b0, 1'b0, -1);
      send_frame(32'hDB6D_B6DB, 1'b0, 1'b0, -1);
      // Consecutive frames with start held: second accepted on first IDLE cycle.
      send_frame(32'h0000_0000, 1'b1, 1'b0, -1);
      send_frame(32'hFFFF_FFFF, 1'b1, 1'b0, -1);
      start = 1'b0;
      @(negedge clk);
      chk_idle("hold_end");
      send_frame(32'h6DB6_1234, 1'b0, 1'b1, -1);
      send_frame(32'hDB6D_B6DB, 1'b0, 1'b0, 12);
      send_frame(32'hDB6D_B6DB, 1'b0, 1'b1, -1);
      for (int r = 0; r < 12; r++) begin
         send_frame($urandom, 1'b0, r[0], -1);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk_idle("gap");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
